// File: rtl/fetch_pkg.sv
// Shared state encoding, widths and helpers for the instruction prefetch path.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // Bits needed to hold any count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with single-cycle clear; head is read straight from the array.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [W-1:0]              i_wdata,
  output logic [W-1:0]              o_rdata,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop & ~i_clear & (r_count != '0);
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_push = i_push & ~i_clear & ((r_count != CW'(DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: sequential imem requests, redirect flush with in-flight discard.
// Optional FETCH_BYPASS_EN presents a response combinationally when the queue is empty.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [31:0]        o_imem_req_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [INSTR_W-1:0] i_imem_rsp_data,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [INSTR_W-1:0] o_instr_data,
  output logic [31:0]        o_instr_pc
);

  localparam int CW = cnt_w(DEPTH);
  localparam int OW = cnt_w(MAX_OUTSTANDING);

  fetch_state_e            r_state;
  fetch_state_e            w_state_next;
  logic                    w_req_enable;
  logic [31:0]             r_fetch_pc;
  logic [31:0]             r_rsp_pc;
  logic [OW-1:0]           r_outstanding;
  logic [OW-1:0]           r_discard;
  logic [OW-1:0]           w_outstanding_next;
  logic [OW-1:0]           w_discard_next;
  logic                    w_accept;
  logic                    w_rsp;
  logic                    w_keep;
  logic                    w_bypass;
  logic                    w_bypass_take;
  logic                    w_push;
  logic                    w_pop;
  logic [CW-1:0]           w_count;
  logic                    w_empty;
  logic [32+INSTR_W-1:0]   w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_START;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_START: w_state_next = S_RUN;
      S_RUN:   if (i_redirect_valid && (w_discard_next != '0)) w_state_next = S_FLUSH;
      S_FLUSH: if (w_discard_next == '0) w_state_next = S_RUN;
      default: w_state_next = S_START;
    endcase
  end

  always_comb begin
    w_req_enable = (r_state != S_START);
  end

  // Reserve a queue slot for every request in flight so responses can never overflow.
  assign o_imem_req_valid = w_req_enable
                          && (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                          && ((32'(w_count) + 32'(r_outstanding)) < 32'(DEPTH));
  assign o_imem_req_addr  = r_fetch_pc;
  assign w_accept         = o_imem_req_valid & i_imem_req_ready;
  assign w_rsp            = i_imem_rsp_valid & (r_outstanding != '0);

  assign w_outstanding_next = r_outstanding + OW'(w_accept) - OW'(w_rsp);

  // Everything still in flight after a redirect belongs to the abandoned stream.
  always_comb begin
    w_discard_next = r_discard;
    if (i_redirect_valid)               w_discard_next = w_outstanding_next;
    else if (w_rsp && r_discard != '0)  w_discard_next = r_discard - 1'b1;
  end

  assign w_keep = w_rsp & (r_discard == '0) & ~i_redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty & w_keep;
`else
  assign w_bypass = 1'b0;
`endif

  assign o_instr_valid = w_bypass | ~w_empty;
  assign w_bypass_take = w_bypass & i_instr_ready;
  assign w_pop         = ~w_empty & i_instr_ready & ~i_redirect_valid;
  assign w_push        = w_keep & ~w_bypass_take;

  always_comb begin
    o_instr_pc   = '0;
    o_instr_data = '0;
    if (w_bypass) begin
      o_instr_pc   = r_rsp_pc;
      o_instr_data = i_imem_rsp_data;
    end else if (!w_empty) begin
      {o_instr_pc, o_instr_data} = w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      if (i_redirect_valid) begin
        r_fetch_pc <= i_redirect_pc;
        r_rsp_pc   <= i_redirect_pc;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'(PC_STEP);
        if (w_keep)   r_rsp_pc   <= r_rsp_pc + 32'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({r_rsp_pc, i_imem_rsp_data}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

`ifndef SYNTHESIS
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    i_imem_rsp_valid |-> (r_outstanding != '0));
`endif

endmodule
